// File: rtl/match_window_counter.sv
// Counts high cycles and rising edges of match over WINDOW-cycle windows; result is
// registered one edge after the last sample, held under backpressure, and overruns set a sticky flag.
module match_window_counter #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             match,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [CNT_W-1:0] res_high,
  output logic [CNT_W-1:0] res_edges,
  output logic             dropped
);

  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] high_acc_q, high_acc_d;
  logic [CNT_W-1:0] edge_acc_q, edge_acc_d;
  logic             match_q;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] res_high_q, res_high_d;
  logic [CNT_W-1:0] res_edges_q, res_edges_d;
  logic             dropped_q, dropped_d;

  // Accumulator values including the current sample, saturating at all-ones.
  logic [CNT_W-1:0] high_nxt;
  logic [CNT_W-1:0] edge_nxt;
  logic             rise;
  logic             complete;

  assign rise = match & ~match_q;

  always_comb begin
    high_nxt = high_acc_q;
    edge_nxt = edge_acc_q;
    if (match && (high_acc_q != CNT_MAX)) begin
      high_nxt = high_acc_q + CNT_W'(1);
    end
    if (rise && (edge_acc_q != CNT_MAX)) begin
      edge_nxt = edge_acc_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    high_acc_d  = high_acc_q;
    edge_acc_d  = edge_acc_q;
    res_valid_d = res_valid_q;
    res_high_d  = res_high_q;
    res_edges_d = res_edges_q;
    dropped_d   = dropped_q;
    complete    = 1'b0;

    if (!en) begin
      // Abort: partial window is discarded, pending result untouched.
      state_d    = IDLE;
      cnt_d      = '0;
      high_acc_d = '0;
      edge_acc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = COUNT;
          cnt_d      = CW'(1);
          high_acc_d = high_nxt;
          edge_acc_d = edge_nxt;
        end
        COUNT: begin
          if (cnt_q == LAST) begin
            complete   = 1'b1;
            state_d    = IDLE;
            cnt_d      = '0;
            high_acc_d = '0;
            edge_acc_d = '0;
          end else begin
            cnt_d      = cnt_q + CW'(1);
            high_acc_d = high_nxt;
            edge_acc_d = edge_nxt;
          end
        end
        default: begin
          state_d    = IDLE;
          cnt_d      = '0;
          high_acc_d = '0;
          edge_acc_d = '0;
        end
      endcase
    end

    if (complete) begin
      if (!res_valid_q || res_ready) begin
        res_valid_d = 1'b1;
        res_high_d  = high_nxt;
        res_edges_d = edge_nxt;
      end else begin
        dropped_d = 1'b1;
      end
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      high_acc_q  <= '0;
      edge_acc_q  <= '0;
      match_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_high_q  <= '0;
      res_edges_q <= '0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      high_acc_q  <= high_acc_d;
      edge_acc_q  <= edge_acc_d;
      match_q     <= match;
      res_valid_q <= res_valid_d;
      res_high_q  <= res_high_d;
      res_edges_q <= res_edges_d;
      dropped_q   <= dropped_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_high  = res_high_q;
  assign res_edges = res_edges_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_match_window_counter.sv
// Scenario bench for match_window_counter: WINDOW=4/CNT_W=8 main instance, WINDOW=8/CNT_W=2 saturation instance.
module tb_match_window_counter;

  logic       clk;
  logic       rst_n;
  logic       en, match, res_ready;
  logic       res_valid, dropped;
  logic [7:0] res_high, res_edges;

  logic       en_s, match_s, ready_s;
  logic       valid_s, dropped_s;
  logic [1:0] high_s, edges_s;

  int errors = 0;
  int checks = 0;
  int exp_h_q[$];
  int exp_e_q[$];

  match_window_counter #(.WINDOW(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .match(match), .res_ready(res_ready),
    .res_valid(res_valid), .res_high(res_high), .res_edges(res_edges), .dropped(dropped)
  );

  match_window_counter #(.WINDOW(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en_s), .match(match_s), .res_ready(ready_s),
    .res_valid(valid_s), .res_high(high_s), .res_edges(edges_s), .dropped(dropped_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus at a falling edge; the following falling edge sees the result.
  task automatic drive(input logic e, input logic m, input logic r);
    en = e; match = m; res_ready = r;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_s = 1'b0; match_s = 1'b0; ready_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = 1'($urandom); match = 1'($urandom); res_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || res_high !== 8'd0 || res_edges !== 8'd0 || dropped !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got valid=%b high=%0d edges=%0d dropped=%b, required 0/0/0/0",
                 i, res_valid, res_high, res_edges, dropped);
      end
    end
    en = 1'b0; match = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int eh, ee;
    drive(1'b0, 1'b0, 1'b0);
    exp_h_q.push_back(3); exp_e_q.push_back(2);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: got %b, required 0", res_valid);
    end
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (res_valid !== 1'b1 || exp_h_q.size() == 0) begin
      errors++; $display("FAIL basic_valid: got %b, required 1", res_valid);
    end else begin
      eh = exp_h_q.pop_front(); ee = exp_e_q.pop_front();
      checks++;
      if (int'(res_high) !== eh || int'(res_edges) !== ee) begin
        errors++; $display("FAIL basic_result: got high=%0d edges=%0d, required %0d %0d", res_high, res_edges, eh, ee);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (res_valid !== 1'b1 || int'(res_high) !== 3) begin
      errors++; $display("FAIL basic_hold: got valid=%b high=%0d, required 1 3", res_valid, res_high);
    end
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL basic_accept: got valid=%b, required 0", res_valid);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_overrun();
    int eh, ee;
    logic [3:0] pat;
    drive(1'b0, 1'b0, 1'b0);
    exp_h_q.push_back(3); exp_e_q.push_back(2);
    pat = 4'b1101;
    for (int i = 0; i < 4; i++) drive(1'b1, pat[i], 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (res_valid !== 1'b1 || dropped !== 1'b1 || exp_h_q.size() == 0) begin
      errors++; $display("FAIL overrun_flags: got valid=%b dropped=%b, required 1 1", res_valid, dropped);
    end else begin
      eh = exp_h_q.pop_front(); ee = exp_e_q.pop_front();
      checks++;
      if (int'(res_high) !== eh || int'(res_edges) !== ee) begin
        errors++; $display("FAIL overrun_held: got high=%0d edges=%0d, required %0d %0d", res_high, res_edges, eh, ee);
      end
    end
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (res_valid !== 1'b0 || dropped !== 1'b1) begin
      errors++; $display("FAIL overrun_accept: got valid=%b dropped=%b, required 0 1", res_valid, dropped);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_same_cycle();
    int eh, ee;
    logic [3:0] pat;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (dropped !== 1'b0) begin
      errors++; $display("FAIL same_reset_dropped: got %b, required 0", dropped);
    end
    exp_h_q.push_back(3); exp_e_q.push_back(2);
    exp_h_q.push_back(1); exp_e_q.push_back(1);
    pat = 4'b1101;
    for (int i = 0; i < 4; i++) drive(1'b1, pat[i], 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (res_valid !== 1'b1 || exp_h_q.size() < 2) begin
      errors++; $display("FAIL same_first_valid: got %b, required 1", res_valid);
    end else begin
      eh = exp_h_q.pop_front(); ee = exp_e_q.pop_front();
      checks++;
      if (int'(res_high) !== eh || int'(res_edges) !== ee) begin
        errors++; $display("FAIL same_first: got high=%0d edges=%0d, required %0d %0d", res_high, res_edges, eh, ee);
      end
    end
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if (res_valid !== 1'b1 || dropped !== 1'b0 || exp_h_q.size() == 0) begin
      errors++; $display("FAIL same_second_valid: got valid=%b dropped=%b, required 1 0", res_valid, dropped);
    end else begin
      eh = exp_h_q.pop_front(); ee = exp_e_q.pop_front();
      checks++;
      if (int'(res_high) !== eh || int'(res_edges) !== ee) begin
        errors++; $display("FAIL same_second: got high=%0d edges=%0d, required %0d %0d", res_high, res_edges, eh, ee);
      end
    end
    drive(1'b0, 1'b0, 1'b1);
    res_ready = 1'b0;
  endtask

  task automatic test_abort();
    int eh, ee;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      checks++;
      if (res_valid !== 1'b0) begin
        errors++; $display("FAIL abort_no_result cyc%0d: got valid=%b, required 0", i, res_valid);
      end
    end
    exp_h_q.push_back(0); exp_e_q.push_back(0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL abort_early: got valid=%b after 3 edges, required 0", res_valid);
    end
    drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (res_valid !== 1'b1 || exp_h_q.size() == 0) begin
      errors++; $display("FAIL abort_next_valid: got %b, required 1", res_valid);
    end else begin
      eh = exp_h_q.pop_front(); ee = exp_e_q.pop_front();
      checks++;
      if (int'(res_high) !== eh || int'(res_edges) !== ee) begin
        errors++; $display("FAIL abort_next: got high=%0d edges=%0d, required %0d %0d", res_high, res_edges, eh, ee);
      end
    end
    drive(1'b0, 1'b0, 1'b1);
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int eh, ee, h, e;
    logic prev, m;
    drive(1'b0, 1'b0, 1'b0);
    prev = 1'b0;
    for (int w = 0; w < 5; w++) begin
      h = 0; e = 0;
      for (int s = 0; s < 4; s++) begin
        m = 1'($urandom);
        if (m) h++;
        if (m && !prev) e++;
        prev = m;
        if (s == 3) begin
          exp_h_q.push_back(h); exp_e_q.push_back(e);
        end
        drive(1'b1, m, 1'b1);
        checks++;
        if (res_valid !== (s == 3)) begin
          errors++; $display("FAIL b2b_valid w%0d s%0d: got %b, required %b", w, s, res_valid, (s == 3));
        end else if (res_valid && exp_h_q.size() != 0) begin
          eh = exp_h_q.pop_front(); ee = exp_e_q.pop_front();
          checks++;
          if (int'(res_high) !== eh || int'(res_edges) !== ee) begin
            errors++; $display("FAIL b2b_result w%0d: got high=%0d edges=%0d, required %0d %0d",
                               w, res_high, res_edges, eh, ee);
          end
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (exp_h_q.size() != 0 || dropped !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got pending=%0d dropped=%b, required 0 0", exp_h_q.size(), dropped);
    end
    exp_h_q.delete(); exp_e_q.delete();
  endtask

  task automatic test_saturation();
    int eh, ee;
    en_s = 1'b0; match_s = 1'b0; ready_s = 1'b0;
    @(negedge clk);
    exp_h_q.push_back(3); exp_e_q.push_back(1);
    for (int i = 0; i < 8; i++) begin
      en_s = 1'b1; match_s = 1'b1;
      @(negedge clk);
      if (i == 6) begin
        checks++;
        if (valid_s !== 1'b0) begin
          errors++; $display("FAIL sat_early: got valid=%b after 7 edges, required 0", valid_s);
        end
      end
    end
    checks++;
    if (valid_s !== 1'b1 || exp_h_q.size() == 0) begin
      errors++; $display("FAIL sat_valid: got %b, required 1", valid_s);
    end else begin
      eh = exp_h_q.pop_front(); ee = exp_e_q.pop_front();
      checks++;
      if (int'(high_s) !== eh || int'(edges_s) !== ee) begin
        errors++; $display("FAIL sat_result: got high=%0d edges=%0d, required %0d %0d", high_s, edges_s, eh, ee);
      end
    end
    en_s = 1'b0; ready_s = 1'b1;
    @(negedge clk);
    ready_s = 1'b0;
  endtask

  initial begin
    en = 1'b0; match = 1'b0; res_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_overrun();
    test_same_cycle();
    test_abort();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
